// File: rtl/nco_phase_accumulator_if.sv
// nco_phase_accumulator_if: control and sample bus between the NCO phase accumulator and its controller.
//   enable       : phase advance enable (master -> slave)
//   fcw_in/load  : frequency control word and its capture strobe (master -> slave)
//   sync_in      : one-cycle hard-sync request (master -> slave)
//   phase_offset : offset added to the output phase (master -> slave)
//   fcw_pending  : shadow word not yet applied (slave -> master)
//   saw_out      : sawtooth phase to the sine LUT (slave -> master)
//   sample_tick  : new saw_out value this cycle (slave -> master)
//   wrap         : accumulator overflowed on this sample (slave -> master)
interface nco_phase_accumulator_if #(
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 11
);
   logic                 enable;
   logic [ACC_WIDTH-1:0] fcw_in;
   logic                 fcw_load;
   logic                 fcw_pending;
   logic                 sync_in;
   logic [OUT_WIDTH-1:0] phase_offset;
   logic [OUT_WIDTH-1:0] saw_out;
   logic                 sample_tick;
   logic                 wrap;
   modport master (
      output enable, fcw_in, fcw_load, sync_in, phase_offset,
      input  fcw_pending, saw_out, sample_tick, wrap
   );
   modport slave (
      input  enable, fcw_in, fcw_load, sync_in, phase_offset,
      output fcw_pending, saw_out, sample_tick, wrap
   );
endinterface

// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator: sample-rate phase accumulator producing the sawtooth phase for the sine ROM.
//   clk : system clock, rising edge
//   rst : synchronous, active-low reset
//   bus : slave side of nco_phase_accumulator_if (enable, FCW load, sync, offset in; saw/tick/wrap out)
module nco_phase_accumulator #(
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 11,
   parameter int SAMPLE_DIV = 2083
) (
   input logic clk,
   input logic rst,
   nco_phase_accumulator_if.slave bus
);
   localparam int DW = $clog2(SAMPLE_DIV);
   logic [DW-1:0]        div_cnt;
   logic [ACC_WIDTH-1:0] acc, fcw_active, fcw_shadow, fcw_eff;
   logic [ACC_WIDTH:0]   sum;
   logic                 fcw_pending, sync_pending, carry_q, stage_v, tick, upd;
   assign tick    = div_cnt == DW'(SAMPLE_DIV - 1);
   assign upd     = tick & bus.enable;
   // a pending shadow word already drives the increment of the tick that applies it
   assign fcw_eff = fcw_pending ? fcw_shadow : fcw_active;
   assign sum     = {1'b0, acc} + {1'b0, fcw_eff};
   assign bus.fcw_pending = fcw_pending;
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt         <= '0;
         acc             <= '0;
         fcw_active      <= '0;
         fcw_shadow      <= '0;
         fcw_pending     <= 1'b0;
         sync_pending    <= 1'b0;
         carry_q         <= 1'b0;
         stage_v         <= 1'b0;
         bus.saw_out     <= '0;
         bus.sample_tick <= 1'b0;
         bus.wrap        <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         stage_v <= upd;
         // a load coinciding with the applying tick re-arms pending with the new word
         if (bus.fcw_load) begin
            fcw_shadow  <= bus.fcw_in;
            fcw_pending <= 1'b1;
         end else if (upd && fcw_pending) fcw_pending <= 1'b0;
         if (upd && fcw_pending) fcw_active <= fcw_shadow;
         // a sync arriving on a tick is only latched; the next tick consumes it
         if (bus.sync_in) sync_pending <= 1'b1;
         else if (upd && sync_pending) sync_pending <= 1'b0;
         if (upd) begin
            acc     <= sync_pending ? '0 : sum[ACC_WIDTH-1:0];
            carry_q <= sync_pending ? 1'b0 : sum[ACC_WIDTH];
         end
         if (stage_v) bus.saw_out <= acc[ACC_WIDTH-1 -: OUT_WIDTH] + bus.phase_offset;
         bus.sample_tick <= stage_v;
         bus.wrap        <= stage_v & carry_q;
      end
   end
endmodule

// File: tb/tb_nco_phase_accumulator.sv
// tb_nco_phase_accumulator: directed self-checking bench for nco_phase_accumulator with SAMPLE_DIV=4.
module tb_nco_phase_accumulator;
   localparam int AW = 32;
   localparam int OW = 11;
   localparam int SD = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   nco_phase_accumulator_if #(.ACC_WIDTH(AW), .OUT_WIDTH(OW)) bus ();
   nco_phase_accumulator #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .SAMPLE_DIV(SD)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic wait_sample(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.sample_tick && n < 20);
      checks++;
      if (bus.sample_tick !== 1'b1) begin
         failures++;
         $display("FAIL wait_sample sample_tick=%b after %0d cycles, required 1", bus.sample_tick, n);
      end
   endtask

   task automatic test_reset();
      int n;
      bus.enable = 1'b1;
      bus.fcw_in = '0;
      bus.fcw_load = 1'b0;
      bus.sync_in = 1'b0;
      bus.phase_offset = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.saw_out, bus.sample_tick, bus.wrap, bus.fcw_pending} !== 14'd0) begin
         failures++;
         $display("FAIL reset_state saw=%0d tick=%b wrap=%b pend=%b, required all 0",
                  bus.saw_out, bus.sample_tick, bus.wrap, bus.fcw_pending);
      end
      rst = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.sample_tick && n < 20);
      checks++;
      if (n !== 5 || bus.saw_out !== 11'd0) begin
         failures++;
         $display("FAIL reset_first_tick cycles=%0d saw=%0d, required 5 and 0", n, bus.saw_out);
      end
   endtask

   task automatic test_ramp_wrap();
      int n;
      bus.fcw_in = 32'h0020_0000;
      bus.fcw_load = 1'b1;
      @(negedge clk);
      bus.fcw_load = 1'b0;
      checks++;
      if (bus.fcw_pending !== 1'b1) begin
         failures++;
         $display("FAIL ramp_pending pend=%b, required 1", bus.fcw_pending);
      end
      for (int i = 1; i <= 2048; i++) begin
         wait_sample(n);
         checks++;
         if (bus.saw_out !== OW'(i % 2048) || bus.wrap !== (i == 2048) || (i > 1 && n != SD)) begin
            failures++;
            $display("FAIL ramp[%0d] saw=%0d wrap=%b spacing=%0d, required %0d %b %0d",
                     i, bus.saw_out, bus.wrap, n, i % 2048, i == 2048, SD);
         end
      end
   endtask

   task automatic test_deferred_fcw();
      int n;
      bus.fcw_in = 32'h0040_0000;
      bus.fcw_load = 1'b1;
      @(negedge clk);
      bus.fcw_load = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.fcw_pending !== 1'b1) begin
         failures++;
         $display("FAIL deferred_pending pend=%b, required 1", bus.fcw_pending);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd2 || bus.fcw_pending !== 1'b0) begin
         failures++;
         $display("FAIL deferred_first saw=%0d pend=%b, required 2 0", bus.saw_out, bus.fcw_pending);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd4) begin
         failures++;
         $display("FAIL deferred_second saw=%0d, required 4", bus.saw_out);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.fcw_in = 32'h0020_0000;
      bus.fcw_load = 1'b1;
      @(negedge clk);
      bus.fcw_in = 32'h0060_0000;
      @(negedge clk);
      bus.fcw_load = 1'b0;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd7) begin
         failures++;
         $display("FAIL back_to_back_first saw=%0d, required 7", bus.saw_out);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd10) begin
         failures++;
         $display("FAIL back_to_back_second saw=%0d, required 10", bus.saw_out);
      end
   endtask

   task automatic test_load_at_tick();
      int n;
      bus.fcw_in = 32'h0020_0000;
      bus.fcw_load = 1'b1;
      @(negedge clk);
      bus.fcw_load = 1'b0;
      @(negedge clk);
      bus.fcw_in = 32'h0040_0000;
      bus.fcw_load = 1'b1;
      @(negedge clk);
      bus.fcw_load = 1'b0;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd11 || bus.fcw_pending !== 1'b1) begin
         failures++;
         $display("FAIL load_at_tick saw=%0d pend=%b, required 11 1", bus.saw_out, bus.fcw_pending);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd13 || bus.fcw_pending !== 1'b0) begin
         failures++;
         $display("FAIL load_at_tick_next saw=%0d pend=%b, required 13 0", bus.saw_out, bus.fcw_pending);
      end
   endtask

   task automatic test_sync();
      int n;
      bus.sync_in = 1'b1;
      @(negedge clk);
      bus.sync_in = 1'b0;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd0 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL sync_apply saw=%0d wrap=%b, required 0 0", bus.saw_out, bus.wrap);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd2) begin
         failures++;
         $display("FAIL sync_after saw=%0d, required 2", bus.saw_out);
      end
      repeat (2) @(negedge clk);
      bus.sync_in = 1'b1;
      @(negedge clk);
      bus.sync_in = 1'b0;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd4) begin
         failures++;
         $display("FAIL sync_at_tick_deferred saw=%0d, required 4", bus.saw_out);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd0) begin
         failures++;
         $display("FAIL sync_at_tick_applied saw=%0d, required 0", bus.saw_out);
      end
   endtask

   task automatic test_offset_wrap();
      int n;
      bus.sync_in = 1'b1;
      bus.fcw_in = 32'd100 << 21;
      bus.fcw_load = 1'b1;
      bus.phase_offset = 11'd2000;
      @(negedge clk);
      bus.sync_in = 1'b0;
      bus.fcw_load = 1'b0;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd2000 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL offset_only saw=%0d wrap=%b, required 2000 0", bus.saw_out, bus.wrap);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd52 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL offset_wrap saw=%0d wrap=%b, required 52 0", bus.saw_out, bus.wrap);
      end
      bus.phase_offset = 11'd5;
      repeat (3) @(negedge clk);
      bus.phase_offset = 11'd7;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd207) begin
         failures++;
         $display("FAIL offset_sampled_late saw=%0d, required 207", bus.saw_out);
      end
   endtask

   task automatic test_enable_gating();
      int n;
      bus.enable = 1'b0;
      for (int i = 0; i < 3 * SD; i++) begin
         bus.sync_in = (i == 5);
         @(negedge clk);
         checks++;
         if (bus.sample_tick !== 1'b0 || bus.saw_out !== 11'd207) begin
            failures++;
            $display("FAIL gated[%0d] tick=%b saw=%0d, required 0 207", i, bus.sample_tick, bus.saw_out);
         end
      end
      bus.sync_in = 1'b0;
      bus.enable = 1'b1;
      bus.phase_offset = '0;
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd0 || bus.wrap !== 1'b0 || n != SD) begin
         failures++;
         $display("FAIL gated_resume saw=%0d wrap=%b cycles=%0d, required 0 0 %0d", bus.saw_out, bus.wrap, n, SD);
      end
      wait_sample(n);
      checks++;
      if (bus.saw_out !== 11'd100) begin
         failures++;
         $display("FAIL gated_resume_next saw=%0d, required 100", bus.saw_out);
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      bus.fcw_in = 32'd5 << 21;
      bus.fcw_load = 1'b1;
      @(negedge clk);
      bus.fcw_load = 1'b0;
      checks++;
      if (bus.fcw_pending !== 1'b1) begin
         failures++;
         $display("FAIL midrst_pending_before pend=%b, required 1", bus.fcw_pending);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if ({bus.saw_out, bus.sample_tick, bus.wrap, bus.fcw_pending} !== 14'd0) begin
         failures++;
         $display("FAIL midrst_cleared saw=%0d tick=%b wrap=%b pend=%b, required all 0",
                  bus.saw_out, bus.sample_tick, bus.wrap, bus.fcw_pending);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.sample_tick && n < 20);
      checks++;
      if (n !== 5 || bus.sample_tick !== 1'b1 || bus.saw_out !== 11'd0 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL midrst_first_tick cycles=%0d tick=%b saw=%0d wrap=%b, required 5 1 0 0",
                  n, bus.sample_tick, bus.saw_out, bus.wrap);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_wrap();
      test_deferred_fcw();
      test_back_to_back();
      test_load_at_tick();
      test_sync();
      test_offset_wrap();
      test_enable_gating();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
